// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_param
//  Description : Parametrised up/down event counter with programmable
//                lower/upper limits, step size, wrap or saturate mode, a
//                registered one-cycle terminal-count pulse and a sticky
//                overflow/underflow flag.
//
//  Parameters  : WIDTH     - counter and limit width in bits (>= 2)
//                STEP_W    - width of the step input (<= WIDTH)
//                RESET_VAL - count value after reset
//
//  Ports       : clk       - clock, rising edge active
//                rst       - synchronous active-high reset
//                load      - load d_in into count (beats enable)
//                enable    - count enable
//                up_down   - 1 = count up, 0 = count down
//                sat_mode  - 1 = saturate at limit, 0 = wrap to other limit
//                d_in      - load value
//                step      - step amount, zero-extended
//                lo_lim    - lower limit (unsigned)
//                hi_lim    - upper limit (unsigned)
//                clr_ovf   - clears the sticky overflow flag
//                count     - registered count
//                tc        - registered terminal-count pulse
//                ovf       - sticky overflow/underflow flag
//                match_val - compare value   (UPDOWN_COUNTER_MATCH_EN only)
//                match     - registered match (UPDOWN_COUNTER_MATCH_EN only)
//
//  Options     : define UPDOWN_COUNTER_MATCH_EN to add the match compare.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int               WIDTH     = 8,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              enable,
    input  logic              up_down,
    input  logic              sat_mode,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    input  logic              clr_ovf,
`ifdef UPDOWN_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0]  match_val,
    output logic              match,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf
);

    logic [WIDTH-1:0]        r_count;
    logic                    r_tc;
    logic                    r_ovf;

    logic [WIDTH:0]          w_step_ext;
    logic [WIDTH:0]          w_sum;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH:0]   w_lo_s;
    logic [WIDTH:0]          w_hi_ext;
    logic                    w_illegal;
    logic [WIDTH-1:0]        w_count_next;
    logic                    w_tc_next;
    logic                    w_ovf_set;

    // One extra bit on both results so a step past either end of the
    // number range is seen as a cross instead of silently wrapping.
    assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign w_sum      = {1'b0, r_count} + w_step_ext;
    assign w_diff     = $signed({1'b0, r_count}) - $signed(w_step_ext);
    assign w_lo_s     = $signed({1'b0, lo_lim});
    assign w_hi_ext   = {1'b0, hi_lim};
    assign w_illegal  = (lo_lim > hi_lim);

    always_comb begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
        w_ovf_set    = 1'b0;
        if (load) begin
            w_count_next = d_in;
        end else if (enable && !w_illegal && (step != '0)) begin
            if (up_down) begin
                if (w_sum < w_hi_ext) begin
                    w_count_next = w_sum[WIDTH-1:0];
                end else if (w_sum == w_hi_ext) begin
                    w_count_next = hi_lim;
                    w_tc_next    = 1'b1;
                end else begin
                    w_count_next = sat_mode ? hi_lim : lo_lim;
                    w_tc_next    = 1'b1;
                    w_ovf_set    = 1'b1;
                end
            end else begin
                if (w_diff > w_lo_s) begin
                    w_count_next = w_diff[WIDTH-1:0];
                end else if (w_diff == w_lo_s) begin
                    w_count_next = lo_lim;
                    w_tc_next    = 1'b1;
                end else begin
                    w_count_next = sat_mode ? lo_lim : hi_lim;
                    w_tc_next    = 1'b1;
                    w_ovf_set    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RESET_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tc    <= w_tc_next;
            // A new cross in the same cycle as a clear must survive.
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_ovf);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

`ifdef UPDOWN_COUNTER_MATCH_EN
    logic r_match;

    // Compares the value being written so match lines up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= (load | enable) && (w_count_next == match_val);
        end
    end

    assign match = r_match;
`endif

endmodule
`default_nettype wire
